// File: rtl/counter_updown_mod.sv
// Up/down modulo counter: enable, direction, sync clear/load, programmable limit,
// tc pulse and sticky wrap flag. Define COUNTER_UPDOWN_MOD_SAT_EN for saturating mode.
module counter_updown_mod #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_end,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH-1:0] wrap_val;

  // >= on the up side so a limit lowered under the count wraps instead of running on
  assign at_end = up ? (count_q >= limit) : (count_q == '0);

`ifdef COUNTER_UPDOWN_MOD_SAT_EN
  assign wrap_val = up ? limit : '0;
`else
  assign wrap_val = up ? '0 : limit;
`endif

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;
    if (clr) begin
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (load) begin
      count_d = (load_val <= limit) ? load_val : limit;
    end else if (en) begin
      if (at_end) begin
        count_d   = wrap_val;
        tc_d      = 1'b1;
        wrapped_d = 1'b1;
      end else if (up) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= RST_V;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;

endmodule
